// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: datapath width, bubble instruction, reset PC
// and the fetch-stage state encoding.
package rv_pipe_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a fetched instruction, holds it under stall,
// and collapses to a NOP bubble on flush or once decode has taken it.
module if_id_reg #(
  parameter int          XLEN      = rv_pipe_pkg::XLEN,
  parameter logic [31:0] NOP_INSTR = rv_pipe_pkg::NOP_INSTR
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            flush_i,
  input  logic            stall_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [31:0]     instr_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
  logic [31:0]     instr_q, instr_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      instr_q    <= NOP_INSTR;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
    end
  end

  // Flush beats load; an unstalled register with nothing new becomes a bubble
  // so decode never sees the same instruction twice.
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    if (flush_i) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (load_i) begin
      valid_d    = 1'b1;
      pc_d       = pc_i;
      pc_plus4_d = pc_i + XLEN'(4);
      instr_d    = instr_i;
    end else if (!stall_i) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
  end

  assign valid_o    = valid_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign instr_o    = instr_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one instruction-memory request
// in flight at a time and feeds decode through the IF/ID register.
module instr_fetch_unit #(
  parameter int              XLEN      = rv_pipe_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = rv_pipe_pkg::RESET_PC,
  parameter logic [31:0]     NOP_INSTR = rv_pipe_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic [31:0]     if_id_instr
);

  import rv_pipe_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic [31:0]     hold_instr_q, hold_instr_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;

  logic            handshake;
  logic [XLEN-1:0] pc_plus4;
  logic            ifid_load;
  logic [XLEN-1:0] ifid_pc;
  logic [31:0]     ifid_instr;

  assign handshake = imem_req_valid && imem_req_ready;
  assign pc_plus4  = pc_q + XLEN'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  // A redirect overrides everything; kill marks an in-flight fetch whose
  // response must be thrown away when it eventually returns.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    if (redirect) begin
      pc_d = redirect_pc & ~XLEN'(3);
      unique case (state_q)
        S_REQ: begin
          if (handshake) begin
            kill_d  = 1'b1;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            kill_d = 1'b1;
          end
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (handshake) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = S_REQ;
            end else if (!if_id_valid || !stall) begin
              pc_d    = pc_plus4;
              state_d = S_REQ;
            end else begin
              hold_instr_d = imem_resp_data;
              hold_pc_d    = pc_q;
              state_d      = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            pc_d    = pc_plus4;
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_comb begin
    imem_req_valid = (state_q == S_REQ) && !rst;
    ifid_load      = 1'b0;
    ifid_pc        = pc_q;
    ifid_instr     = imem_resp_data;
    if (state_q == S_WAIT && imem_resp_valid && !kill_q && (!if_id_valid || !stall)) begin
      ifid_load = 1'b1;
    end else if (state_q == S_HOLD && !stall) begin
      ifid_load  = 1'b1;
      ifid_pc    = hold_pc_q;
      ifid_instr = hold_instr_q;
    end
  end

  assign imem_req_addr = pc_q;

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (ifid_load),
    .flush_i    (redirect),
    .stall_i    (stall),
    .pc_i       (ifid_pc),
    .instr_i    (ifid_instr),
    .valid_o    (if_id_valid),
    .pc_o       (if_id_pc),
    .pc_plus4_o (if_id_pc_plus4),
    .instr_o    (if_id_instr)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a one-outstanding memory model feeds a scoreboard
// of the architectural fetch stream that decode should observe.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .XLEN      (32),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .if_id_valid     (if_id_valid),
    .if_id_pc        (if_id_pc),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .if_id_instr     (if_id_instr)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  fetch_t      expQ[$];
  int          checks = 0;
  int          errors = 0;
  logic        drvRst = 1'b1, drvReady = 1'b1, drvStall = 1'b0, drvRedirect = 1'b0;
  logic [31:0] drvRpc = '0;
  int          extraLat = 0;
  logic        pendValid = 1'b0;
  logic [31:0] pendAddr = '0;
  int          pendTag = 0, pendCnt = 0;
  int          epoch = 0;
  logic [31:0] expPc = '0;
  int          consumed = 0;
  logic        prevWait = 1'b0;
  logic [31:0] prevAddr = '0;
  logic [31:0] pcA;
  int          c0;

  function automatic logic [31:0] memData(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h0010_8113;
    return (a * 32'd3) ^ 32'h1234_5673;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs and the memory response, observe the DUT
  // mid-cycle, update the scoreboard, then advance to just after the next edge.
  task automatic applyStimulus();
    logic   delivering;
    logic   busy;
    int     epochIn;
    fetch_t e;
    busy       = pendValid;
    epochIn    = epoch;
    delivering = 1'b0;
    if (pendValid && pendCnt == 0) delivering = 1'b1;
    else if (pendValid) pendCnt--;
    imem_resp_valid = delivering;
    imem_resp_data  = delivering ? memData(pendAddr) : 32'hDEAD_BEEF;
    rst             = drvRst;
    imem_req_ready  = drvReady;
    stall           = drvStall;
    redirect        = drvRedirect;
    redirect_pc     = drvRpc;
    #1;
    if (drvRst) begin
      checkOutput("rstReqValid", imem_req_valid, 0);
      epoch++;
      expQ.delete();
      expPc = 32'h0;
    end else if (drvRedirect) begin
      epoch++;
      expQ.delete();
      expPc = {drvRpc[31:2], 2'b00};
    end
    if (delivering) begin
      pendValid = 1'b0;
      if (pendTag == epoch) begin
        checkOutput("fetchAddr", pendAddr, expPc);
        e.pc    = pendAddr;
        e.instr = memData(pendAddr);
        expQ.push_back(e);
        expPc += 32'd4;
      end
    end
    if (!drvRst && !if_id_valid) checkOutput("bubbleNop", if_id_instr, NOP);
    if (prevWait && !drvRst) begin
      checkOutput("holdReqValid", imem_req_valid, 1);
      checkOutput("holdReqAddr", imem_req_addr, prevAddr);
    end
    prevWait = imem_req_valid && !drvReady && !drvRedirect && !drvRst;
    prevAddr = imem_req_addr;
    if (imem_req_valid && drvReady) begin
      checkOutput("oneOutstanding", busy, 0);
      pendValid = 1'b1;
      pendAddr  = imem_req_addr;
      pendTag   = epochIn;
      pendCnt   = extraLat;
    end
    if (!drvRst && !drvRedirect && if_id_valid && !drvStall) begin
      if (expQ.size() == 0) begin
        checkOutput("spuriousValid", if_id_valid, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("ifIdPc", if_id_pc, e.pc);
        checkOutput("ifIdInstr", if_id_instr, e.instr);
        checkOutput("ifIdPcPlus4", if_id_pc_plus4, e.pc + 32'd4);
        consumed++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic waitReq(input string tag);
    int n = 0;
    while (!imem_req_valid && n < 20) begin
      applyStimulus();
      n++;
    end
    checkOutput(tag, imem_req_valid, 1);
  endtask

  task automatic waitIfId(input string tag);
    int n = 0;
    while (!if_id_valid && n < 20) begin
      applyStimulus();
      n++;
    end
    checkOutput(tag, if_id_valid, 1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired, simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values and zero-wait first fetch latency.
    drvRst = 1'b1;
    repeat (3) applyStimulus();
    checkOutput("rstIfIdValid", if_id_valid, 0);
    checkOutput("rstIfIdInstr", if_id_instr, NOP);
    checkOutput("rstIfIdPc", if_id_pc, 0);
    checkOutput("rstIfIdPc4", if_id_pc_plus4, 0);
    drvRst = 1'b0;
    applyStimulus();
    checkOutput("firstReqAccepted", pendValid, 1);
    applyStimulus();
    checkOutput("lat2Valid", if_id_valid, 1);
    checkOutput("lat2Pc", if_id_pc, 32'h0);
    checkOutput("lat2Instr", if_id_instr, 32'h0050_0093);
    checkOutput("lat2Pc4", if_id_pc_plus4, 32'h4);
    checkOutput("secondReqAddr", imem_req_addr, 32'h4);
    repeat (3) applyStimulus();

    // Memory back-pressure.
    waitReq("reqBeforeReadyLow");
    drvReady = 1'b0;
    repeat (3) applyStimulus();
    c0 = consumed;
    drvReady = 1'b1;
    repeat (4) applyStimulus();
    checkOutput("oneRespAfterReady", consumed - c0, 1);

    // Stall with a full IF/ID parks the response in the hold buffer.
    waitIfId("ifIdBeforeStall");
    pcA = if_id_pc;
    drvStall = 1'b1;
    repeat (5) applyStimulus();
    checkOutput("holdNoReq", imem_req_valid, 0);
    checkOutput("frozenValid", if_id_valid, 1);
    checkOutput("frozenPc", if_id_pc, pcA);
    drvStall = 1'b0;
    applyStimulus();
    checkOutput("heldAppearsPc", if_id_pc, pcA + 32'd4);
    checkOutput("resumeReqValid", imem_req_valid, 1);
    checkOutput("resumeReqAddr", imem_req_addr, pcA + 32'd8);
    repeat (3) applyStimulus();

    // Redirect on the request handshake cycle.
    waitReq("reqBeforeRedirect");
    drvRedirect = 1'b1; drvRpc = 32'h100;
    applyStimulus();
    drvRedirect = 1'b0;
    checkOutput("flushValid", if_id_valid, 0);
    checkOutput("flushInstr", if_id_instr, NOP);
    applyStimulus();
    checkOutput("redirReqValid", imem_req_valid, 1);
    checkOutput("redirReqAddr", imem_req_addr, 32'h100);
    repeat (2) applyStimulus();
    checkOutput("redirIfIdValid", if_id_valid, 1);
    checkOutput("redirIfIdPc", if_id_pc, 32'h100);
    repeat (3) applyStimulus();

    // Redirect beats stall while a response sits in the hold buffer.
    waitIfId("ifIdBeforeHoldRedirect");
    drvStall = 1'b1;
    repeat (5) applyStimulus();
    checkOutput("inHoldNoReq", imem_req_valid, 0);
    drvRedirect = 1'b1; drvRpc = 32'h203;
    applyStimulus();
    drvRedirect = 1'b0; drvStall = 1'b0;
    checkOutput("holdRedirValid", imem_req_valid, 1);
    checkOutput("holdRedirAddr", imem_req_addr, 32'h200);
    checkOutput("holdRedirFlush", if_id_valid, 0);
    repeat (6) applyStimulus();

    // PC wrap at the top of the address space.
    drvRedirect = 1'b1; drvRpc = 32'hFFFF_FFFC;
    applyStimulus();
    drvRedirect = 1'b0;
    waitIfId("wrapIfIdValid");
    checkOutput("wrapPc", if_id_pc, 32'hFFFF_FFFC);
    checkOutput("wrapPc4", if_id_pc_plus4, 32'h0);
    checkOutput("wrapNextReqAddr", imem_req_addr, 32'h0);
    repeat (4) applyStimulus();

    // Redirect while waiting on a slow response.
    waitReq("reqBeforeSlow");
    extraLat = 2;
    applyStimulus();
    extraLat = 0;
    drvRedirect = 1'b1; drvRpc = 32'h400;
    applyStimulus();
    drvRedirect = 1'b0;
    waitReq("reqAfterKill");
    checkOutput("killReqAddr", imem_req_addr, 32'h400);
    repeat (6) applyStimulus();

    // Reset in the middle of a transaction.
    waitReq("reqBeforeMidReset");
    applyStimulus();
    drvRst = 1'b1;
    repeat (2) applyStimulus();
    drvRst = 1'b0;
    checkOutput("midRstIfIdValid", if_id_valid, 0);
    repeat (6) applyStimulus();

    // Random mix of back-pressure, stalls, latency and redirects.
    c0 = consumed;
    for (int i = 0; i < 300; i++) begin
      drvReady    = ($urandom_range(0, 3) != 0);
      drvStall    = ($urandom_range(0, 3) == 0);
      drvRedirect = ($urandom_range(0, 15) == 0);
      drvRpc      = $urandom;
      extraLat    = $urandom_range(0, 2);
      applyStimulus();
    end
    drvReady = 1'b1; drvStall = 1'b0; drvRedirect = 1'b0; extraLat = 0;
    repeat (10) applyStimulus();
    checkOutput("randomProgress", (consumed > c0 + 20) ? 1 : 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
